// File: rtl/keynsham_sdram_arb.sv
// Data/instruction arbiter onto the single sdram_controller host port.
// Define SDRAM_ARB_TIMEOUT_EN to add a host-port watchdog that completes a stalled grant with an error.
module keynsham_sdram_arb #(
  parameter int max_d_wins = 4,
  parameter int timeout    = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        d_access,
  input  logic        d_cs,
  input  logic [29:0] d_addr,
  input  logic [31:0] d_wr_val,
  input  logic        d_wr_en,
  input  logic [3:0]  d_bytesel,
  output logic        d_ack,
  output logic        d_error,
  output logic [31:0] d_data,
  input  logic        i_access,
  input  logic        i_cs,
  input  logic [29:0] i_addr,
  output logic        i_ack,
  output logic        i_error,
  output logic [31:0] i_data,
  input  logic        h_config_done,
  output logic        h_cs,
  output logic [29:0] h_addr,
  output logic        h_wr_en,
  output logic [3:0]  h_bytesel,
  output logic [31:0] h_wdata,
  input  logic        h_compl,
  input  logic [31:0] h_rdata
);

  localparam int WIN_W = $clog2(max_d_wins + 1);
  localparam logic [WIN_W-1:0] WIN_MAX = WIN_W'(max_d_wins);

  typedef enum logic [1:0] {ST_IDLE, ST_GNT_D, ST_GNT_I} state_t;

  state_t           state_q, state_d;
  logic             pend_d_q, pend_i_q;
  logic [WIN_W-1:0] win_q;
  logic [29:0]      d_addr_q, i_addr_q;
  logic [31:0]      d_wdata_q;
  logic             d_wr_en_q;
  logic [3:0]       d_bytesel_q;
  logic             grant_d, grant_i;
  logic             d_owned, i_owned;
  logic             to_fire, done;
  logic             d_take, i_take;

  assign d_owned = (state_q == ST_GNT_D);
  assign i_owned = (state_q == ST_GNT_I);

`ifdef SDRAM_ARB_TIMEOUT_EN
  localparam int TO_W = $clog2(timeout + 1);
  logic [TO_W-1:0] to_cnt_q;

  // Counts cycles of the current grant; IDLE always separates grants, so it restarts at 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 to_cnt_q <= '0;
    else if (state_q == ST_IDLE) to_cnt_q <= '0;
    else                        to_cnt_q <= to_cnt_q + 1'b1;
  end

  assign to_fire = (state_q != ST_IDLE) && !h_compl && (to_cnt_q == TO_W'(timeout - 1));
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (timeout > 0);
  assign to_fire = 1'b0;
`endif

  assign done = (state_q != ST_IDLE) && (h_compl || to_fire);

  // A bus's slot frees on its completion cycle, so a new pulse then is captured.
  assign d_take = d_access && d_cs && !pend_d_q && !(d_owned && !done);
  assign i_take = i_access && i_cs && !pend_i_q && !(i_owned && !done);

  always_comb begin
    // NOTE: every output of this block gets a default first so no latch is inferred.
    state_d = state_q;
    grant_d = 1'b0;
    grant_i = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (h_config_done) begin
          if (pend_i_q && (win_q == WIN_MAX)) grant_i = 1'b1;
          else if (pend_d_q)                 grant_d = 1'b1;
          else if (pend_i_q)                 grant_i = 1'b1;
        end
        if (grant_d)      state_d = ST_GNT_D;
        else if (grant_i) state_d = ST_GNT_I;
      end
      ST_GNT_D, ST_GNT_I: if (done) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      pend_d_q  <= 1'b0;
      pend_i_q  <= 1'b0;
      win_q     <= '0;
      h_addr    <= '0;
      h_wr_en   <= 1'b0;
      h_bytesel <= '0;
      h_wdata   <= '0;
    end else begin
      state_q <= state_d;
      if (grant_d)     pend_d_q <= 1'b0;
      else if (d_take) pend_d_q <= 1'b1;
      if (grant_i)     pend_i_q <= 1'b0;
      else if (i_take) pend_i_q <= 1'b1;

      if (grant_d) begin
        h_addr    <= d_addr_q;
        h_wr_en   <= d_wr_en_q;
        h_bytesel <= d_bytesel_q;
        h_wdata   <= d_wdata_q;
        if (pend_i_q) win_q <= (win_q == WIN_MAX) ? win_q : win_q + 1'b1;
        else          win_q <= '0;
      end else if (grant_i) begin
        h_addr    <= i_addr_q;
        h_wr_en   <= 1'b0;
        h_bytesel <= 4'b1111;
        h_wdata   <= '0;
        win_q     <= '0;
      end
    end
  end

  // NOTE: request payload is only meaningful while its pending flag is set, so it carries no reset.
  always_ff @(posedge clk) begin
    if (d_take) begin
      d_addr_q    <= d_addr;
      d_wdata_q   <= d_wr_val;
      d_wr_en_q   <= d_wr_en;
      d_bytesel_q <= d_bytesel;
    end
    if (i_take) i_addr_q <= i_addr;
  end

  assign h_cs    = (state_q != ST_IDLE);
  assign d_ack   = d_owned && (h_compl || to_fire);
  assign i_ack   = i_owned && (h_compl || to_fire);
  assign d_error = d_owned && to_fire;
  assign i_error = i_owned && to_fire;
  assign d_data  = (d_owned && h_compl) ? h_rdata : 32'h0;
  assign i_data  = (i_owned && h_compl) ? h_rdata : 32'h0;

endmodule

// File: tb/tb_keynsham_sdram_arb.sv
// Directed self-checking bench for keynsham_sdram_arb (timeout scenario needs SDRAM_ARB_TIMEOUT_EN).
module tb_keynsham_sdram_arb;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        d_access, d_cs, d_wr_en;
  logic [29:0] d_addr;
  logic [31:0] d_wr_val;
  logic [3:0]  d_bytesel;
  logic        d_ack, d_error;
  logic [31:0] d_data;
  logic        i_access, i_cs;
  logic [29:0] i_addr;
  logic        i_ack, i_error;
  logic [31:0] i_data;
  logic        h_config_done, h_cs, h_wr_en, h_compl;
  logic [29:0] h_addr;
  logic [3:0]  h_bytesel;
  logic [31:0] h_wdata, h_rdata;

  int n_checks = 0;
  int n_fail   = 0;

  keynsham_sdram_arb #(.max_d_wins(4), .timeout(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .d_access(d_access), .d_cs(d_cs), .d_addr(d_addr), .d_wr_val(d_wr_val),
    .d_wr_en(d_wr_en), .d_bytesel(d_bytesel), .d_ack(d_ack), .d_error(d_error), .d_data(d_data),
    .i_access(i_access), .i_cs(i_cs), .i_addr(i_addr), .i_ack(i_ack), .i_error(i_error), .i_data(i_data),
    .h_config_done(h_config_done), .h_cs(h_cs), .h_addr(h_addr), .h_wr_en(h_wr_en),
    .h_bytesel(h_bytesel), .h_wdata(h_wdata), .h_compl(h_compl), .h_rdata(h_rdata)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic pulse_d(input logic [29:0] a, input logic [31:0] wv, input logic we, input logic [3:0] bs);
    d_addr = a; d_wr_val = wv; d_wr_en = we; d_bytesel = bs;
    d_access = 1'b1; d_cs = 1'b1;
    tick();
    d_access = 1'b0;
  endtask

  task automatic pulse_i(input logic [29:0] a);
    i_addr = a; i_access = 1'b1; i_cs = 1'b1;
    tick();
    i_access = 1'b0;
  endtask

  task automatic wait_grant(output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 16; k++) begin
      if (h_cs) begin ok = 1'b1; break; end
      tick();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #3;
    n_checks++; if ({h_cs, h_addr, h_wr_en, h_bytesel, h_wdata} !== 68'h0) begin n_fail++; $display("FAIL reset_host: got %h expected 0", {h_cs, h_addr, h_wr_en, h_bytesel, h_wdata}); end
    n_checks++; if ({d_ack, d_error, i_ack, i_error, d_data, i_data} !== 68'h0) begin n_fail++; $display("FAIL reset_bus: got %h expected 0", {d_ack, d_error, i_ack, i_error, d_data, i_data}); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_config_gate();
    bit stuck = 1'b0;
    pulse_d(30'h50, 32'h0, 1'b0, 4'b1111);
    for (int k = 0; k < 4; k++) begin
      if (h_cs !== 1'b0) stuck = 1'b1;
      tick();
    end
    n_checks++; if (stuck) begin n_fail++; $display("FAIL cfg_gate: h_cs rose before config_done, expected 0"); end
    h_config_done = 1'b1;
    tick();
    n_checks++; if (h_cs !== 1'b1 || h_addr !== 30'h50) begin n_fail++; $display("FAIL cfg_grant: got cs=%b addr=%h expected cs=1 addr=050", h_cs, h_addr); end
    h_compl = 1'b1; h_rdata = 32'h1; #1;
    n_checks++; if (d_ack !== 1'b1) begin n_fail++; $display("FAIL cfg_ack: got %b expected 1", d_ack); end
    tick();
    h_compl = 1'b0; #1;
    n_checks++; if (h_cs !== 1'b0) begin n_fail++; $display("FAIL cfg_release: got %b expected 0", h_cs); end
  endtask

  task automatic test_single_read();
    pulse_d(30'h100, 32'h0, 1'b0, 4'b1111);
    tick();
    n_checks++; if (h_cs !== 1'b1 || h_addr !== 30'h100 || h_wr_en !== 1'b0) begin n_fail++; $display("FAIL read_req: got cs=%b addr=%h we=%b expected 1/100/0", h_cs, h_addr, h_wr_en); end
    repeat (4) tick();
    h_compl = 1'b1; h_rdata = 32'hDEADBEEF; #1;
    n_checks++; if (d_ack !== 1'b1 || d_data !== 32'hDEADBEEF) begin n_fail++; $display("FAIL read_ack: got ack=%b data=%h expected 1/deadbeef", d_ack, d_data); end
    n_checks++; if (i_ack !== 1'b0 || d_error !== 1'b0) begin n_fail++; $display("FAIL read_side: got i_ack=%b d_error=%b expected 0/0", i_ack, d_error); end
    tick();
    h_compl = 1'b0; #1;
    n_checks++; if (d_ack !== 1'b0 || d_data !== 32'h0 || h_cs !== 1'b0) begin n_fail++; $display("FAIL read_after: got ack=%b data=%h cs=%b expected 0/0/0", d_ack, d_data, h_cs); end
  endtask

  task automatic test_simultaneous();
    d_addr = 30'h200; d_wr_val = 32'h0BADF00D; d_wr_en = 1'b1; d_bytesel = 4'b0001;
    i_addr = 30'h300;
    d_access = 1'b1; d_cs = 1'b1; i_access = 1'b1; i_cs = 1'b1;
    tick();
    d_access = 1'b0; i_access = 1'b0;
    tick();
    n_checks++; if (h_cs !== 1'b1 || h_addr !== 30'h200 || h_wr_en !== 1'b1) begin n_fail++; $display("FAIL simul_first: got cs=%b addr=%h we=%b expected 1/200/1", h_cs, h_addr, h_wr_en); end
    h_compl = 1'b1; #1;
    n_checks++; if (d_ack !== 1'b1 || i_ack !== 1'b0) begin n_fail++; $display("FAIL simul_dack: got d=%b i=%b expected 1/0", d_ack, i_ack); end
    tick();
    h_compl = 1'b0; #1;
    n_checks++; if (h_cs !== 1'b0) begin n_fail++; $display("FAIL simul_gap: got cs=%b expected 0", h_cs); end
    tick();
    n_checks++; if ({h_cs, h_addr, h_bytesel, h_wr_en} !== {1'b1, 30'h300, 4'b1111, 1'b0}) begin n_fail++; $display("FAIL simul_ireq: got %h expected %h", {h_cs, h_addr, h_bytesel, h_wr_en}, {1'b1, 30'h300, 4'b1111, 1'b0}); end
    h_compl = 1'b1; h_rdata = 32'hCAFEF00D; #1;
    n_checks++; if (i_ack !== 1'b1 || i_data !== 32'hCAFEF00D || d_ack !== 1'b0) begin n_fail++; $display("FAIL simul_iack: got i_ack=%b i_data=%h d_ack=%b expected 1/cafef00d/0", i_ack, i_data, d_ack); end
    tick();
    h_compl = 1'b0; #1;
  endtask

  task automatic test_starvation();
    bit ok;
    logic exp_d;
    logic [29:0] exp_addr;
    d_addr = 30'h400; d_wr_en = 1'b0; d_bytesel = 4'b1111; i_addr = 30'h3FF;
    d_access = 1'b1; i_access = 1'b1;
    tick();
    d_access = 1'b0; i_access = 1'b0;
    for (int g = 0; g < 5; g++) begin
      exp_d    = (g < 4);
      exp_addr = exp_d ? 30'h400 + 30'(g) : 30'h3FF;
      wait_grant(ok);
      n_checks++; if (!ok) begin n_fail++; $display("FAIL starve_wait%0d: no grant within bound", g); end
      n_checks++; if (h_addr !== exp_addr) begin n_fail++; $display("FAIL starve_addr%0d: got %h expected %h", g, h_addr, exp_addr); end
      if (g == 4) begin
        n_checks++; if (dut.win_q !== '0) begin n_fail++; $display("FAIL starve_wincnt: got %0d expected 0", dut.win_q); end
      end
      tick();
      h_compl = 1'b1;
      if (exp_d) begin d_addr = 30'h401 + 30'(g); d_access = 1'b1; end
      #1;
      n_checks++; if (d_ack !== exp_d || i_ack !== !exp_d) begin n_fail++; $display("FAIL starve_owner%0d: got d=%b i=%b expected d=%b", g, d_ack, i_ack, exp_d); end
      tick();
      h_compl = 1'b0; d_access = 1'b0; #1;
    end
    wait_grant(ok);
    n_checks++; if (!ok || h_addr !== 30'h404) begin n_fail++; $display("FAIL starve_drain: got ok=%b addr=%h expected 1/404", ok, h_addr); end
    h_compl = 1'b1; tick();
    h_compl = 1'b0; #1;
    n_checks++; if (dut.win_q !== '0) begin n_fail++; $display("FAIL starve_winend: got %0d expected 0", dut.win_q); end
  endtask

  task automatic test_write_stable();
    logic [67:0] exp_h;
    exp_h = {1'b1, 30'h2A, 1'b1, 4'b0011, 32'h12345678};
    pulse_d(30'h2A, 32'h12345678, 1'b1, 4'b0011);
    tick();
    n_checks++; if ({h_cs, h_addr, h_wr_en, h_bytesel, h_wdata} !== exp_h) begin n_fail++; $display("FAIL write_req: got %h expected %h", {h_cs, h_addr, h_wr_en, h_bytesel, h_wdata}, exp_h); end
    for (int k = 0; k < 4; k++) begin
      d_addr = 30'h3000 + 30'(k); d_wr_val = 32'hFFFF0000 + 32'(k); d_wr_en = k[0]; d_bytesel = 4'(k + 4);
      d_access = 1'b1;
      tick();
      n_checks++; if ({h_cs, h_addr, h_wr_en, h_bytesel, h_wdata} !== exp_h) begin n_fail++; $display("FAIL write_stable%0d: got %h expected %h", k, {h_cs, h_addr, h_wr_en, h_bytesel, h_wdata}, exp_h); end
    end
    d_access = 1'b0;
    h_compl = 1'b1; #1;
    n_checks++; if (d_ack !== 1'b1) begin n_fail++; $display("FAIL write_ack: got %b expected 1", d_ack); end
    tick();
    h_compl = 1'b0;
    tick();
    n_checks++; if (h_cs !== 1'b0) begin n_fail++; $display("FAIL write_ignored: got cs=%b expected 0", h_cs); end
  endtask

`ifdef SDRAM_ARB_TIMEOUT_EN
  task automatic test_timeout();
    bit early = 1'b0;
    h_rdata = 32'hA5A5A5A5;
    pulse_d(30'h77, 32'h0, 1'b0, 4'b1111);
    tick();
    for (int c = 1; c < 16; c++) begin
      if (d_ack !== 1'b0 || h_cs !== 1'b1) early = 1'b1;
      tick();
    end
    n_checks++; if (early) begin n_fail++; $display("FAIL to_early: ack or cs wrong before cycle 16"); end
    n_checks++; if ({d_ack, d_error, d_data, h_cs} !== {1'b1, 1'b1, 32'h0, 1'b1}) begin n_fail++; $display("FAIL to_fire: got ack=%b err=%b data=%h cs=%b expected 1/1/0/1", d_ack, d_error, d_data, h_cs); end
    tick();
    n_checks++; if (h_cs !== 1'b0 || d_ack !== 1'b0) begin n_fail++; $display("FAIL to_release: got cs=%b ack=%b expected 0/0", h_cs, d_ack); end
    h_compl = 1'b1; #1;
    n_checks++; if (d_ack !== 1'b0 || i_ack !== 1'b0) begin n_fail++; $display("FAIL to_late: got d=%b i=%b expected 0/0", d_ack, i_ack); end
    tick();
    h_compl = 1'b0;
    pulse_i(30'h88);
    tick();
    n_checks++; if (h_cs !== 1'b1 || h_addr !== 30'h88) begin n_fail++; $display("FAIL to_ireq: got cs=%b addr=%h expected 1/088", h_cs, h_addr); end
    tick();
    h_compl = 1'b1; h_rdata = 32'h55; #1;
    n_checks++; if ({i_ack, i_error, i_data} !== {1'b1, 1'b0, 32'h55}) begin n_fail++; $display("FAIL to_iack: got ack=%b err=%b data=%h expected 1/0/55", i_ack, i_error, i_data); end
    tick();
    h_compl = 1'b0; #1;
  endtask
`endif

  task automatic test_reset_mid_grant();
    pulse_d(30'h99, 32'h0, 1'b0, 4'b1111);
    tick();
    n_checks++; if (h_cs !== 1'b1) begin n_fail++; $display("FAIL rstmid_grant: got %b expected 1", h_cs); end
    tick();
    #2;
    rst_n = 1'b0; h_compl = 1'b1;
    #1;
    n_checks++; if (h_cs !== 1'b0 || d_ack !== 1'b0 || h_addr !== 30'h0) begin n_fail++; $display("FAIL rstmid_drop: got cs=%b ack=%b addr=%h expected 0/0/0", h_cs, d_ack, h_addr); end
    @(negedge clk);
    rst_n = 1'b1; h_compl = 1'b0;
    tick();
    tick();
    n_checks++; if (h_cs !== 1'b0) begin n_fail++; $display("FAIL rstmid_clear: got %b expected 0", h_cs); end
  endtask

  initial begin
    rst_n = 1'b0;
    d_access = 1'b0; d_cs = 1'b0; d_addr = '0; d_wr_val = '0; d_wr_en = 1'b0; d_bytesel = '0;
    i_access = 1'b0; i_cs = 1'b0; i_addr = '0;
    h_config_done = 1'b0; h_compl = 1'b0; h_rdata = '0;
    test_reset();
    test_config_gate();
    test_single_read();
    test_simultaneous();
    test_starvation();
    test_write_stable();
`ifdef SDRAM_ARB_TIMEOUT_EN
    test_timeout();
`endif
    test_reset_mid_grant();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
